// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the pipelined Wishbone round-robin arbiter.
package wb_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ABORT = 2'd2
   } arb_state_t;

   // Counter/index width that never collapses to zero bits.
   function automatic int clog2_min1(input int value);
      return (value > 1) ? $clog2(value) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester searching upward from last+1.
module rr_picker
   import wb_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int IW          = clog2_min1(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] i_req,
   input  logic [IW-1:0]          i_last,
   output logic [NUM_MASTERS-1:0] o_grant,
   output logic [IW-1:0]          o_idx,
   output logic                   o_valid
);

   int w_cand;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_cand  = 0;
      // Offset NUM_MASTERS wraps back to i_last itself, so it is considered last.
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         w_cand = int'(i_last) + k;
         if (w_cand >= NUM_MASTERS) begin
            w_cand = w_cand - NUM_MASTERS;
         end
         if (!o_valid && i_req[w_cand[IW-1:0]]) begin
            o_valid                  = 1'b1;
            o_idx                    = w_cand[IW-1:0];
            o_grant[w_cand[IW-1:0]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Pipelined Wishbone B4 arbiter: round-robin ownership per cyc, bounded
// outstanding strobes, and a watchdog that aborts a stuck cycle with err.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS     = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 256,
   parameter int AW              = 32,
   parameter int DW              = 32
) (
   input  logic                                clk_i,
   input  logic                                rstn_i,
   // requester ports
   input  logic [NUM_MASTERS-1:0]              i_m_cyc,
   input  logic [NUM_MASTERS-1:0]              i_m_stb,
   input  logic [NUM_MASTERS-1:0]              i_m_we,
   input  logic [NUM_MASTERS-1:0][AW-1:0]      i_m_adr,
   input  logic [NUM_MASTERS-1:0][DW/8-1:0]    i_m_sel,
   input  logic [NUM_MASTERS-1:0][DW-1:0]      i_m_dat,
   output logic [DW-1:0]                       o_m_dat,
   output logic [NUM_MASTERS-1:0]              o_m_ack,
   output logic [NUM_MASTERS-1:0]              o_m_err,
   output logic [NUM_MASTERS-1:0]              o_m_rty,
   output logic [NUM_MASTERS-1:0]              o_m_stall,
   // shared bus port
   output logic                                o_s_cyc,
   output logic                                o_s_stb,
   output logic                                o_s_we,
   output logic [AW-1:0]                       o_s_adr,
   output logic [DW/8-1:0]                     o_s_sel,
   output logic [DW-1:0]                       o_s_dat,
   input  logic [DW-1:0]                       i_s_dat,
   input  logic                                i_s_ack,
   input  logic                                i_s_err,
   input  logic                                i_s_rty,
   input  logic                                i_s_stall,
   // status
   output logic [NUM_MASTERS-1:0]              grant_o,
   output logic                                timeout_o
);

   localparam int IW = clog2_min1(NUM_MASTERS);
   localparam int OW = clog2_min1(MAX_OUTSTANDING + 1);
   localparam int TW = clog2_min1(TIMEOUT_CYCLES + 1);

   localparam logic [OW-1:0] MAX_OUT  = OW'(MAX_OUTSTANDING);
   localparam logic [TW-1:0] TIMEOUT  = TW'(TIMEOUT_CYCLES);
   localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);

   arb_state_t             r_state, w_state_next;
   logic [NUM_MASTERS-1:0] r_grant, w_grant_next;
   logic [IW-1:0]          r_last_grant, w_last_grant_next;
   logic [OW-1:0]          r_outstanding, w_outstanding_next;
   logic [TW-1:0]          r_timer, w_timer_next;

   logic [NUM_MASTERS-1:0] w_pick_grant;
   logic [IW-1:0]          w_pick_idx;
   logic                   w_pick_valid;

   logic w_busy, w_abort, w_room, w_has_out, w_term, w_accept;
   logic w_g_cyc, w_g_stb;

   rr_picker #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_picker (
      .i_req   (i_m_cyc),
      .i_last  (r_last_grant),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_valid)
   );

   // While BUSY or ABORT, r_last_grant is the index of the current owner.
   assign w_busy    = (r_state == BUSY);
   assign w_abort   = (r_state == ABORT);
   assign w_room    = (r_outstanding < MAX_OUT);
   assign w_has_out = (r_outstanding != '0);
   assign w_g_cyc   = i_m_cyc[r_last_grant];
   assign w_g_stb   = i_m_stb[r_last_grant];
   assign w_term    = i_s_ack | i_s_err | i_s_rty;

   assign o_s_cyc  = w_busy & w_g_cyc;
   assign o_s_stb  = w_busy & w_g_stb & w_room;
   assign o_s_we   = i_m_we[r_last_grant];
   assign o_s_adr  = i_m_adr[r_last_grant];
   assign o_s_sel  = i_m_sel[r_last_grant];
   assign o_s_dat  = i_m_dat[r_last_grant];
   assign o_m_dat  = i_s_dat;
   assign w_accept = o_s_stb & ~i_s_stall;

   assign grant_o   = r_grant;
   assign timeout_o = w_abort;

   for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      logic w_route;
      // Terminations with nothing outstanding are spurious and never reach a master.
      assign w_route        = w_busy & r_grant[gi] & w_has_out;
      assign o_m_ack[gi]    = w_route & i_s_ack;
      assign o_m_rty[gi]    = w_route & i_s_rty;
      assign o_m_err[gi]    = (w_route & i_s_err) | (w_abort & r_grant[gi]);
      assign o_m_stall[gi]  = ~(w_busy & r_grant[gi] & w_room) | i_s_stall;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state       <= IDLE;
         r_grant       <= '0;
         r_last_grant  <= LAST_RST;
         r_outstanding <= '0;
         r_timer       <= '0;
      end else begin
         r_state       <= w_state_next;
         r_grant       <= w_grant_next;
         r_last_grant  <= w_last_grant_next;
         r_outstanding <= w_outstanding_next;
         r_timer       <= w_timer_next;
      end
   end

   always_comb begin
      w_state_next       = r_state;
      w_grant_next       = r_grant;
      w_last_grant_next  = r_last_grant;
      w_outstanding_next = r_outstanding;
      w_timer_next       = r_timer;

      unique case (r_state)
         IDLE: begin
            w_outstanding_next = '0;
            w_timer_next       = '0;
            if (w_pick_valid) begin
               w_grant_next      = w_pick_grant;
               w_last_grant_next = w_pick_idx;
               w_state_next      = BUSY;
            end
         end

         BUSY: begin
            if (!w_g_cyc) begin
               // Release always passes through IDLE, giving one idle cycle between owners.
               w_state_next       = IDLE;
               w_grant_next       = '0;
               w_outstanding_next = '0;
               w_timer_next       = '0;
            end else begin
               unique case ({w_accept, w_has_out & w_term})
                  2'b10:   w_outstanding_next = r_outstanding + OW'(1);
                  2'b01:   w_outstanding_next = r_outstanding - OW'(1);
                  default: w_outstanding_next = r_outstanding;
               endcase
               if ((TIMEOUT_CYCLES != 0) && w_has_out && !w_term) begin
                  w_timer_next = r_timer + TW'(1);
               end else begin
                  w_timer_next = '0;
               end
               if ((TIMEOUT_CYCLES != 0) && (w_timer_next == TIMEOUT)) begin
                  w_state_next = ABORT;
               end
            end
         end

         ABORT: begin
            w_state_next       = IDLE;
            w_grant_next       = '0;
            w_outstanding_next = '0;
            w_timer_next       = '0;
         end

         default: begin
            w_state_next       = IDLE;
            w_grant_next       = '0;
            w_outstanding_next = '0;
            w_timer_next       = '0;
         end
      endcase
   end

endmodule
